pll_lock_reset_seq: RTL and testbench
=====================================

Name: pll_lock_reset_seq

Overview:
Fabric reset sequencer directly downstream of the MSS clock-conditioning block. It consumes the CCC lock outputs (FAB_LOCK, MSS_LOCK), which are asynchronous to the fabric clock, and synchronises them. It holds the fabric logic in reset until lock has been continuously stable for a programmable time. On loss of lock it re-asserts reset for a minimum hold time, flags the event and counts it.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each lock synchroniser; legal range 2..4.
STABLE_CYCLES, 1024, consecutive locked FAB_CLK cycles required before reset is released; must be >= 2.
HOLD_CYCLES, 16, minimum FAB_CLK cycles spent in HOLD after a lock loss; must be >= 1.
CNT_W, 8, width of the lock-loss counter.

Ports:
FAB_CLK  in  1  fabric clock; the only clock.
M2F_RESET_N  in  1  reset, synchronous, active-low.
FAB_LOCK  in  1  CCC fabric lock; asynchronous.
MSS_LOCK  in  1  CCC MSS lock; asynchronous.
FAB_RESET_N  out  1  registered fabric reset, active-low.
LOCK_STABLE  out  1  high while in RUN.
LOSS_EVENT  out  1  one-cycle pulse on each lock loss seen in RUN.
LOSS_CNT  out  CNT_W  saturating count of lock losses.
SEQ_STATE  out  3  encoded current state, for debug.

Behaviour:
- Interface (already decided): one clock, FAB_CLK. Reset M2F_RESET_N is synchronous and active-low.
- Synchronisers: FAB_LOCK and MSS_LOCK each pass through their own SYNC_STAGES-flop chain. lock_s = AND of the two synchronised bits.
- While M2F_RESET_N=0 (sampled at an edge), all outputs and internal state are forced as follows:
  - synchroniser flops = 0
  - state = WAIT_LOCK
  - counters = 0
  - FAB_RESET_N = 0, LOCK_STABLE = 0, LOSS_EVENT = 0, LOSS_CNT = 0.
- Reset applied mid-operation takes effect at the next edge from any state. LOSS_CNT is cleared as well.
- States and encodings: WAIT_LOCK=0, STABILIZE=1, RUN=2, HOLD=3.
- WAIT_LOCK: if lock_s=1, go to STABILIZE with stab_cnt=0.
- STABILIZE:
  - If lock_s=0, return to WAIT_LOCK and clear stab_cnt. No loss event is raised.
  - Otherwise stab_cnt increments. When stab_cnt reaches STABLE_CYCLES-1 with lock_s=1, go to RUN.
- RUN:
  - FAB_RESET_N=1 and LOCK_STABLE=1, both registered and asserted on the edge that enters RUN.
  - If lock_s=0: go to HOLD. On that same edge FAB_RESET_N=0, LOCK_STABLE=0, LOSS_EVENT=1 for exactly one cycle, and LOSS_CNT increments.
- HOLD:
  - hold_cnt counts HOLD_CYCLES cycles, then the block goes to WAIT_LOCK regardless of lock_s.
  - A lock that returns during HOLD does not shorten the hold.
- Latency: from the first edge sampling FAB_LOCK=MSS_LOCK=1, FAB_RESET_N rises exactly SYNC_STAGES+STABLE_CYCLES+1 edges later.
- Lock-loss latency: from the edge sampling lock low while in RUN, FAB_RESET_N falls exactly SYNC_STAGES+1 edges later.
- LOSS_CNT saturates at 2^CNT_W-1 and never wraps. LOSS_EVENT still pulses when the counter is saturated.
- Glitches: a lock dropout shorter than one cycle may be missed by the synchroniser, which is acceptable. Any lock_s low in STABILIZE restarts the stability window.
- stab_cnt width = clog2(STABLE_CYCLES); hold_cnt width = clog2(HOLD_CYCLES+1).
- SEQ_STATE outputs the current state encoding; undefined encodings recover to WAIT_LOCK.

Optional Feature:
MSS_LOCK_QUAL_EN
- Defined: lock_s = sync(FAB_LOCK) AND sync(MSS_LOCK), as described above.
- Undefined: MSS_LOCK is ignored, its synchroniser is not built, and lock_s = sync(FAB_LOCK).
- Port lists are identical either way.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum: WAIT_LOCK, STABILIZE, RUN, HOLD with 3-bit encodings;
  - SEQ_STATE_W=3;
  - the default constants STABLE_CYCLES_DFLT=1024 and HOLD_CYCLES_DFLT=16.
- One natural sub-module: lock_sync, a parameterised N-flop synchroniser with synchronous active-low clear. It is instantiated once per lock input.

Test Plan:
- Lock-up latency: SYNC_STAGES=2, STABLE_CYCLES=16. Release reset, then raise FAB_LOCK and MSS_LOCK at edge 0 -> FAB_RESET_N and LOCK_STABLE rise at edge 19; LOSS_CNT=0.
- Unstable lock: drop FAB_LOCK for 3 cycles after 10 locked cycles -> state returns to WAIT_LOCK, no LOSS_EVENT, stability window restarts, FAB_RESET_N stays 0.
- Lock loss in RUN with HOLD_CYCLES=16: drop MSS_LOCK -> FAB_RESET_N falls 3 edges later, one LOSS_EVENT pulse, LOSS_CNT=1. Restore lock immediately -> HOLD still lasts 16 cycles, then re-lock completes.
- Saturation with CNT_W=2: 5 RUN lock losses -> LOSS_CNT sequence 1,2,3,3,3; LOSS_EVENT pulses all 5 times.
- Reset mid-HOLD: assert M2F_RESET_N=0 for 1 cycle -> state=WAIT_LOCK, LOSS_CNT=0, FAB_RESET_N=0 on that edge.
- Macro off: MSS_LOCK held 0, FAB_LOCK=1 -> FAB_RESET_N rises at edge 19. With macro on, the same stimulus keeps FAB_RESET_N=0 indefinitely.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock reset sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pll_seq_pkg;

    // Width of the debug state encoding exported on SEQ_STATE.
    localparam int SEQ_STATE_W = 3;

    // Default stability window and post-loss hold, in fabric clock cycles.
    localparam int STABLE_CYCLES_DFLT = 1024;
    localparam int HOLD_CYCLES_DFLT   = 16;

    // Sequencer states; encodings are visible on SEQ_STATE for debug.
    typedef enum logic [SEQ_STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        RUN       = 3'd2,
        HOLD      = 3'd3
    } seq_state_e;

endpackage

// File: rtl/lock_sync.sv
// N-flop synchroniser for a level signal, synchronous active-low clear.
// Latency: STAGES clock edges from d to q.
// Backpressure: none; free-running level path.
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // Shift the asynchronous input through the flop chain; clear forces all stages low.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Fabric reset sequencer: holds FAB_RESET_N low until CCC lock is stable, re-asserts on loss.
// Latency: lock-up SYNC_STAGES+STABLE_CYCLES+1 edges; lock-loss SYNC_STAGES+1 edges.
// Backpressure: none; MSS_LOCK qualifies lock only when MSS_LOCK_QUAL_EN is defined.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DFLT,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DFLT,
    parameter int CNT_W         = 8
) (
    input  logic                   FAB_CLK,
    input  logic                   M2F_RESET_N,
    input  logic                   FAB_LOCK,
    input  logic                   MSS_LOCK,
    output logic                   FAB_RESET_N,
    output logic                   LOCK_STABLE,
    output logic                   LOSS_EVENT,
    output logic [CNT_W-1:0]       LOSS_CNT,
    output logic [SEQ_STATE_W-1:0] SEQ_STATE
);

    localparam int STAB_W = $clog2(STABLE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic              fab_lock_s;
    logic              lock_raw;
    logic              lock_q;

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic [STAB_W-1:0] stab_cnt_q;
    logic [STAB_W-1:0] stab_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              loss_d;

    logic              fab_reset_n_q;
    logic              lock_stable_q;
    logic              loss_event_q;
    logic [CNT_W-1:0]  loss_cnt_q;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_fab_sync (
        .clk   (FAB_CLK),
        .clr_n (M2F_RESET_N),
        .d     (FAB_LOCK),
        .q     (fab_lock_s)
    );

`ifdef MSS_LOCK_QUAL_EN
    logic mss_lock_s;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_mss_sync (
        .clk   (FAB_CLK),
        .clr_n (M2F_RESET_N),
        .d     (MSS_LOCK),
        .q     (mss_lock_s)
    );

    assign lock_raw = fab_lock_s & mss_lock_s;
`else
    // MSS lock is not qualified in this build; the port stays for a fixed pinout.
    logic unused_mss_lock;
    assign unused_mss_lock = MSS_LOCK;
    assign lock_raw        = fab_lock_s;
`endif

    // Register the combined lock so the FSM sees one clean, glitch-free level.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_raw;
        end
    end

    // State and counter registers.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            state_q    <= WAIT_LOCK;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic: stability window, run, and minimum hold after a loss.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        loss_d     = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                stab_cnt_d = '0;
                hold_cnt_d = '0;
                if (lock_q) begin
                    state_d = STABILIZE;
                end
            end

            STABILIZE: begin
                if (!lock_q) begin
                    // Any dropout restarts the window; not a loss event.
                    state_d    = WAIT_LOCK;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = RUN;
                    stab_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end

            RUN: begin
                if (!lock_q) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    loss_d     = 1'b1;
                end
            end

            HOLD: begin
                // Hold runs its full length even if lock comes back early.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d    = WAIT_LOCK;
                stab_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Registered outputs, updated on the same edge as the state transition.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            fab_reset_n_q <= 1'b0;
            lock_stable_q <= 1'b0;
            loss_event_q  <= 1'b0;
            loss_cnt_q    <= '0;
        end else begin
            fab_reset_n_q <= (state_d == RUN);
            lock_stable_q <= (state_d == RUN);
            loss_event_q  <= loss_d;
            // Saturate rather than wrap; the event pulse still fires when full.
            if (loss_d && (loss_cnt_q != CNT_MAX)) begin
                loss_cnt_q <= loss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign FAB_RESET_N = fab_reset_n_q;
    assign LOCK_STABLE = lock_stable_q;
    assign LOSS_EVENT  = loss_event_q;
    assign LOSS_CNT    = loss_cnt_q;
    assign SEQ_STATE   = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq (SYNC=2, STABLE=16, HOLD=16, CNT_W=2).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pll_lock_reset_seq;

    logic       fab_clk;
    logic       m2f_reset_n;
    logic       fab_lock;
    logic       mss_lock;
    logic       fab_reset_n;
    logic       lock_stable;
    logic       loss_event;
    logic [1:0] loss_cnt;
    logic [2:0] seq_state;

    int n_vec;
    int n_miss;

    pll_lock_reset_seq #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16),
        .HOLD_CYCLES   (16),
        .CNT_W         (2)
    ) dut (
        .FAB_CLK     (fab_clk),
        .M2F_RESET_N (m2f_reset_n),
        .FAB_LOCK    (fab_lock),
        .MSS_LOCK    (mss_lock),
        .FAB_RESET_N (fab_reset_n),
        .LOCK_STABLE (lock_stable),
        .LOSS_EVENT  (loss_event),
        .LOSS_CNT    (loss_cnt),
        .SEQ_STATE   (seq_state)
    );

    initial fab_clk = 1'b0;
    always #5 fab_clk = ~fab_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge fab_clk);
        #1;
    endtask

    // Drop whichever lock input qualifies lock in this build.
    task automatic drop_lock();
`ifdef MSS_LOCK_QUAL_EN
        mss_lock = 1'b0;
`else
        fab_lock = 1'b0;
`endif
    endtask

    task automatic restore_lock();
        fab_lock = 1'b1;
        mss_lock = 1'b1;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        m2f_reset_n = 1'b0;
        fab_lock    = 1'b0;
        mss_lock    = 1'b0;

        // Reset state
        tick(3);
        chk("rst_fab_reset_n", fab_reset_n, 0);
        chk("rst_lock_stable", lock_stable, 0);
        chk("rst_loss_event",  loss_event,  0);
        chk("rst_loss_cnt",    loss_cnt,    0);
        chk("rst_state",       seq_state,   0);
        m2f_reset_n = 1'b1;
        tick(2);
        chk("idle_state", seq_state, 0);

        // Lock-up: locks sampled high at edge 0, reset released at edge 19
        restore_lock();
        tick(3);
        chk("up_e2_state", seq_state, 0);
        tick(1);
        chk("up_e3_state", seq_state, 1);
        tick(15);
        chk("up_e18_rstn",  fab_reset_n, 0);
        chk("up_e18_state", seq_state,   1);
        tick(1);
        chk("up_e19_rstn",   fab_reset_n, 1);
        chk("up_e19_stable", lock_stable, 1);
        chk("up_e19_state",  seq_state,   2);
        chk("up_e19_cnt",    loss_cnt,    0);

        // Lock loss in RUN with immediate restore: falls 3 edges later, full hold
        drop_lock();
        tick(1);
        restore_lock();
        tick(2);
        chk("loss_e2_rstn", fab_reset_n, 1);
        chk("loss_e2_ev",   loss_event,  0);
        tick(1);
        chk("loss_e3_rstn",   fab_reset_n, 0);
        chk("loss_e3_stable", lock_stable, 0);
        chk("loss_e3_ev",     loss_event,  1);
        chk("loss_e3_cnt",    loss_cnt,    1);
        chk("loss_e3_state",  seq_state,   3);
        tick(1);
        chk("loss_e4_ev",    loss_event, 0);
        chk("loss_e4_state", seq_state,  3);
        tick(14);
        chk("hold_e18_state", seq_state, 3);
        tick(1);
        chk("hold_e19_state", seq_state, 0);
        tick(16);
        chk("relock_e35_rstn", fab_reset_n, 0);
        tick(1);
        chk("relock_e36_rstn", fab_reset_n, 1);
        chk("relock_e36_cnt",  loss_cnt,    1);

        // Reset applied mid-HOLD
        drop_lock();
        tick(5);
        chk("mid_hold_state", seq_state, 3);
        chk("mid_hold_cnt",   loss_cnt,  2);
        m2f_reset_n = 1'b0;
        tick(1);
        chk("rst_hold_state",  seq_state,   0);
        chk("rst_hold_cnt",    loss_cnt,    0);
        chk("rst_hold_rstn",   fab_reset_n, 0);
        chk("rst_hold_stable", lock_stable, 0);
        m2f_reset_n = 1'b1;
        fab_lock    = 1'b0;
        mss_lock    = 1'b0;
        tick(4);

        // Unstable lock: 3-cycle FAB_LOCK dropout after 10 locked cycles
        restore_lock();
        tick(13);
        chk("unst_e12_state", seq_state, 1);
        fab_lock = 1'b0;
        tick(3);
        chk("unst_e15_state", seq_state, 1);
        fab_lock = 1'b1;
        tick(1);
        chk("unst_e16_state", seq_state,  0);
        chk("unst_e16_ev",    loss_event, 0);
        tick(2);
        chk("unst_e18_state", seq_state,  0);
        chk("unst_e18_ev",    loss_event, 0);
        tick(1);
        chk("unst_e19_state", seq_state,   1);
        chk("unst_e19_rstn",  fab_reset_n, 0);
        tick(15);
        chk("unst_e34_rstn", fab_reset_n, 0);
        tick(1);
        chk("unst_e35_rstn", fab_reset_n, 1);
        chk("unst_e35_cnt",  loss_cnt,    0);

        // Saturation: five losses with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drop_lock();
            tick(1);
            restore_lock();
            tick(2);
            chk("sat_pre_ev", loss_event, 0);
            tick(1);
            chk("sat_ev",  loss_event, 1);
            chk("sat_cnt", loss_cnt, (i + 1 > 3) ? 3 : i + 1);
            tick(1);
            chk("sat_post_ev", loss_event, 0);
            tick(32);
            chk("sat_relock_state", seq_state, 2);
        end

        // FAB_LOCK high, MSS_LOCK low: qualification depends on the build
        m2f_reset_n = 1'b0;
        fab_lock    = 1'b0;
        mss_lock    = 1'b0;
        tick(4);
        m2f_reset_n = 1'b1;
        tick(1);
        fab_lock = 1'b1;
        mss_lock = 1'b0;
        tick(19);
        chk("qual_e18_rstn", fab_reset_n, 0);
        tick(1);
`ifdef MSS_LOCK_QUAL_EN
        chk("qual_e19_rstn",  fab_reset_n, 0);
        chk("qual_e19_state", seq_state,   0);
        tick(50);
        chk("qual_e69_rstn", fab_reset_n, 0);
`else
        chk("qual_e19_rstn",  fab_reset_n, 1);
        chk("qual_e19_state", seq_state,   2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
